// File: rtl/reg_file_mp.sv
// Multi-port register file for the RV32IM ID/RF stage: two write ports, NUM_READ
// combinational read ports, optional write-to-read bypass and a pending-write scoreboard.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           WRITE_ENABLE0,
  input  logic [ADDR_WIDTH-1:0]          WRITE_ADDR0,
  input  logic [DATA_WIDTH-1:0]          WRITE_DATA0,
  input  logic                           WRITE_ENABLE1,
  input  logic [ADDR_WIDTH-1:0]          WRITE_ADDR1,
  input  logic [DATA_WIDTH-1:0]          WRITE_DATA1,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] OUT_ADDR,
  output logic [NUM_READ*DATA_WIDTH-1:0] DATA_OUT,
  output logic [NUM_READ-1:0]            BUSY_OUT,
  input  logic                           BUSY_SET_EN,
  input  logic [ADDR_WIDTH-1:0]          BUSY_SET_ADDR,
  input  logic                           FLUSH
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  logic w_we0;
  logic w_we1;
  logic w_busy_set;

  // Register 0 is hard-wired when ZERO_REG is set: it is never written nor marked busy,
  // so it keeps its reset value of zero and can never match a bypass.
  assign w_we0      = WRITE_ENABLE0 && !((ZERO_REG != 0) && (WRITE_ADDR0 == ZERO_ADDR));
  assign w_we1      = WRITE_ENABLE1 && !((ZERO_REG != 0) && (WRITE_ADDR1 == ZERO_ADDR));
  assign w_busy_set = BUSY_SET_EN   && !((ZERO_REG != 0) && (BUSY_SET_ADDR == ZERO_ADDR));

  // NOTE: the architectural registers must read zero straight out of reset, so the whole
  // array is cleared asynchronously here; this keeps it as flops rather than an SRAM macro.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_we0) r_regs[WRITE_ADDR0] <= WRITE_DATA0;
      // NOTE: when several non-blocking assignments hit the same element in one block,
      // the last one executed wins; that ordering is what gives port 1 priority.
      if (w_we1) r_regs[WRITE_ADDR1] <= WRITE_DATA1;
    end
  end

  // Scoreboard priority comes from statement order: the set for the newest issued
  // instruction overrides a flush, which overrides writeback clears.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_busy <= '0;
    end else begin
      if (FLUSH) begin
        r_busy <= '0;
      end else begin
        if (w_we0) r_busy[WRITE_ADDR0] <= 1'b0;
        if (w_we1) r_busy[WRITE_ADDR1] <= 1'b0;
      end
      if (w_busy_set) r_busy[BUSY_SET_ADDR] <= 1'b1;
    end
  end

  for (genvar gk = 0; gk < NUM_READ; gk++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_byp0;
    logic                  w_byp1;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_addr = OUT_ADDR[gk*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_byp0 = (BYPASS != 0) && w_we0 && (WRITE_ADDR0 == w_addr);
    assign w_byp1 = (BYPASS != 0) && w_we1 && (WRITE_ADDR1 == w_addr);

    always_comb begin
      w_data = r_regs[w_addr];
      if (w_byp1) begin
        w_data = WRITE_DATA1;
      end else if (w_byp0) begin
        w_data = WRITE_DATA0;
      end
    end

    // Gating with RESET_N keeps a bypassed write from leaking out while in reset.
    assign DATA_OUT[gk*DATA_WIDTH +: DATA_WIDTH] = RESET_N ? w_data : '0;
    assign BUSY_OUT[gk] = RESET_N && r_busy[w_addr] && !(w_byp0 || w_byp1);
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus;
// expectations are queued by the stimulus and compared by an independent monitor.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef struct {
    string       name;
    int          dut;   // 0: BYPASS=1 instance, 1: BYPASS=0 instance
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           we0, we1, set_en, flush;
  logic [AW-1:0]  wa0, wa1, set_addr;
  logic [DW-1:0]  wd0, wd1;
  logic [NR*AW-1:0] out_addr;
  logic [NR*DW-1:0] data_a, data_b;
  logic [NR-1:0]  busy_a, busy_b;

  exp_t q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
    .CLK(clk), .RESET_N(rst_n),
    .WRITE_ENABLE0(we0), .WRITE_ADDR0(wa0), .WRITE_DATA0(wd0),
    .WRITE_ENABLE1(we1), .WRITE_ADDR1(wa1), .WRITE_DATA1(wd1),
    .OUT_ADDR(out_addr), .DATA_OUT(data_a), .BUSY_OUT(busy_a),
    .BUSY_SET_EN(set_en), .BUSY_SET_ADDR(set_addr), .FLUSH(flush)
  );

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_nobyp (
    .CLK(clk), .RESET_N(rst_n),
    .WRITE_ENABLE0(we0), .WRITE_ADDR0(wa0), .WRITE_DATA0(wd0),
    .WRITE_ENABLE1(we1), .WRITE_ADDR1(wa1), .WRITE_DATA1(wd1),
    .OUT_ADDR(out_addr), .DATA_OUT(data_b), .BUSY_OUT(busy_b),
    .BUSY_SET_EN(set_en), .BUSY_SET_ADDR(set_addr), .FLUSH(flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t        e;
    logic [31:0] got_d;
    logic        got_b;
    forever begin
      @(sample_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        got_d = (e.dut == 0) ? data_a[e.port*DW +: DW] : data_b[e.port*DW +: DW];
        got_b = (e.dut == 0) ? busy_a[e.port] : busy_b[e.port];
        check({e.name, (e.dut == 0) ? "_byp_data" : "_nobyp_data"}, got_d, e.data);
        check({e.name, (e.dut == 0) ? "_byp_busy" : "_nobyp_busy"}, {31'b0, got_b}, {31'b0, e.busy});
      end
    end
  end

  task automatic push(input string name, input int dut, input int port,
                      input logic [31:0] data, input logic busy);
    exp_t e;
    e.name = name; e.dut = dut; e.port = port; e.data = data; e.busy = busy;
    q.push_back(e);
  endtask

  // Expectation for both instances: (data, busy) for the bypass build, then the other.
  task automatic exp2(input string name, input int port,
                      input logic [31:0] da, input logic ba,
                      input logic [31:0] db, input logic bb);
    push(name, 0, port, da, ba);
    push(name, 1, port, db, bb);
  endtask

  task automatic sample();
    -> sample_ev;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; set_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    out_addr[port*AW +: AW] = a;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we0 = 1'b1; wa0 = a; wd0 = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we1 = 1'b1; wa1 = a; wd1 = d;
  endtask

  task automatic bset(input logic [AW-1:0] a);
    set_en = 1'b1; set_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; set_addr = '0; out_addr = '0;
    #2;

    // A write presented during reset must not be bypassed to the outputs.
    wr0(5'd5, 32'hDEADBEEF); rd(0, 5'd5); rd(1, 5'd5);
    exp2("rst_hold_p0", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp2("rst_hold_p1", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a)); rd(1, 5'(31 - a));
      exp2($sformatf("rst_x%0d_p0", a), 0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp2($sformatf("rst_x%0d_p1", 31 - a), 1, 32'h0, 1'b0, 32'h0, 1'b0);
      sample();
    end
    tick();

    // x5 write, then asynchronous reset between edges.
    wr0(5'd5, 32'hDEADBEEF); rd(0, 5'd5);
    exp2("x5_wr_cycle", 0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    sample();
    tick(); idle();
    exp2("x5_after", 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    sample();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp2("x5_midrst", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();
    rst_n = 1'b1;
    tick();

    // Both write ports hit x3: port 1 wins, in the array and on the bypass.
    wr0(5'd3, 32'h11111111); wr1(5'd3, 32'h22222222); rd(0, 5'd3); rd(1, 5'd5);
    exp2("x3_dual_wr", 0, 32'h22222222, 1'b0, 32'h0, 1'b0);
    exp2("x5_cleared", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();
    tick(); idle(); rd(1, 5'd3);
    exp2("x3_p0_after", 0, 32'h22222222, 1'b0, 32'h22222222, 1'b0);
    exp2("x3_p1_after", 1, 32'h22222222, 1'b0, 32'h22222222, 1'b0);
    sample();

    // Write to an address that only one read port targets.
    wr0(5'd6, 32'h66666666); rd(1, 5'd6);
    exp2("x3_unrelated", 0, 32'h22222222, 1'b0, 32'h22222222, 1'b0);
    exp2("x6_wr_cycle", 1, 32'h66666666, 1'b0, 32'h0, 1'b0);
    sample();
    tick(); idle();
    exp2("x6_after", 1, 32'h66666666, 1'b0, 32'h66666666, 1'b0);
    sample();

    // x0 is hard-wired to zero and never busy.
    wr0(5'd0, 32'hFFFFFFFF); wr1(5'd0, 32'h12345678); rd(0, 5'd0); rd(1, 5'd0);
    exp2("x0_wr_p0", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp2("x0_wr_p1", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();
    tick(); idle();
    exp2("x0_after", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();
    bset(5'd0);
    tick(); idle();
    exp2("x0_busy_set", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();

    // x7 pending, resolved by the mul/div port three cycles later.
    bset(5'd7); rd(1, 5'd7);
    exp2("x7_set_cycle", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    sample();
    tick(); idle();
    exp2("x7_busy_c1", 1, 32'h0, 1'b1, 32'h0, 1'b1);
    sample();
    tick();
    exp2("x7_busy_c2", 1, 32'h0, 1'b1, 32'h0, 1'b1);
    sample();
    tick();
    wr1(5'd7, 32'h00000042);
    exp2("x7_wr_cycle", 1, 32'h00000042, 1'b0, 32'h0, 1'b1);
    sample();
    tick(); idle();
    exp2("x7_after", 1, 32'h00000042, 1'b0, 32'h00000042, 1'b0);
    sample();

    // Set and write of x9 in one cycle keeps x9 busy; then flush with a set of x4.
    bset(5'd12);
    tick(); idle();
    bset(5'd9); wr0(5'd9, 32'h99999999); rd(0, 5'd9); rd(1, 5'd12);
    exp2("x9_set_wr", 0, 32'h99999999, 1'b0, 32'h0, 1'b0);
    exp2("x12_pending", 1, 32'h0, 1'b1, 32'h0, 1'b1);
    sample();
    tick(); idle();
    exp2("x9_still_busy", 0, 32'h99999999, 1'b1, 32'h99999999, 1'b1);
    sample();
    flush = 1'b1; bset(5'd4); rd(0, 5'd4); rd(1, 5'd9);
    exp2("x4_flush_cycle", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp2("x9_flush_cycle", 1, 32'h99999999, 1'b1, 32'h99999999, 1'b1);
    sample();
    tick(); idle();
    exp2("x4_after_flush", 0, 32'h0, 1'b1, 32'h0, 1'b1);
    exp2("x9_after_flush", 1, 32'h99999999, 1'b0, 32'h99999999, 1'b0);
    sample();
    rd(0, 5'd12); rd(1, 5'd7);
    exp2("x12_after_flush", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp2("x7_after_flush", 1, 32'h00000042, 1'b0, 32'h00000042, 1'b0);
    sample();

    // Bypass disabled: old value during the write cycle, new value afterwards.
    tick();
    wr0(5'd2, 32'hA5A5A5A5); rd(0, 5'd2);
    exp2("x2_wr_cycle", 0, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    sample();
    tick(); idle();
    exp2("x2_after", 0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0);
    sample();

    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the RV32IM ID/RF stage. Provides two write ports, for the ALU writeback and the long-latency mul/div writeback, and NUM_READ combinational read ports. Includes an optional same-cycle write-to-read bypass and a per-register pending-write scoreboard, which the hazard unit uses to stall on unresolved destinations.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, when 1, register 0 reads as zero, is never written and is never busy
BYPASS, 1, when 1, a write in the current cycle is forwarded to matching read ports

Ports:
CLK  input  1  clock; all state updates on posedge
RESET_N  input  1  asynchronous active-low reset
WRITE_ENABLE0  input  1  write port 0 enable (ALU writeback)
WRITE_ADDR0  input  ADDR_WIDTH  write port 0 address
WRITE_DATA0  input  DATA_WIDTH  write port 0 data
WRITE_ENABLE1  input  1  write port 1 enable (mul/div writeback)
WRITE_ADDR1  input  ADDR_WIDTH  write port 1 address
WRITE_DATA1  input  DATA_WIDTH  write port 1 data
OUT_ADDR  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
DATA_OUT  output  NUM_READ*DATA_WIDTH  packed read data, same packing
BUSY_OUT  output  NUM_READ  per read port: the addressed register has a pending write
BUSY_SET_EN  input  1  mark BUSY_SET_ADDR as pending (instruction issued with that rd)
BUSY_SET_ADDR  input  ADDR_WIDTH  destination register being marked
FLUSH  input  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset: RESET_N low clears every register and every busy bit to 0 immediately, independent of CLK. While RESET_N is low, DATA_OUT is all zero and BUSY_OUT is 0. Reset asserted mid-operation discards any write or busy-set in that cycle.
- Writes are synchronous at posedge CLK. A new value is visible in the array from the cycle after the edge.
- Both ports writing the same address in the same cycle: port 1 wins.
- ZERO_REG=1: writes to address 0 are ignored, and reads of address 0 return 0 on every port.
- Reads are combinational from the array, with zero clock latency.
- BYPASS=1: if a write enable is high and its address matches a read address (and is not address 0 with ZERO_REG=1), DATA_OUT for that port shows the write data in the same cycle. If both write ports match, port 1 data is shown.
- BYPASS=0: reads return the pre-edge array contents only.
- Scoreboard: one busy bit per register.
  - Set at posedge when BUSY_SET_EN=1.
  - Cleared at posedge for each address written with its enable high.
  - Update priority, highest first: BUSY_SET_EN, then FLUSH, then write clears.
  - Same-address set and write in the same cycle leaves the bit set, because the set belongs to the newer instruction.
  - FLUSH with BUSY_SET_EN clears all bits except BUSY_SET_ADDR, which ends set.
  - BUSY_SET_EN to address 0 with ZERO_REG=1 is ignored.
- BUSY_OUT[k] = busy[addr_k] AND NOT (BYPASS=1 AND a same-cycle write to addr_k). A bypassed value is therefore never reported as busy.
- No internal FSM beyond the array and scoreboard. Each busy bit is a two-state idle/pending machine.
- All address arithmetic is unsigned. Out-of-range addresses cannot occur because depth is exactly 2**ADDR_WIDTH.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every DATA_OUT is 0 and BUSY_OUT is 00. Assert RESET_N low between clock edges after writing x5=0xDEADBEEF -> x5 reads 0 immediately.
- WE0 writes x3=0x11111111 and WE1 writes x3=0x22222222 in the same cycle -> next cycle x3 reads 0x22222222. With BYPASS=1, port 0 reading x3 during that cycle shows 0x22222222.
- WE0 writes x0=0xFFFFFFFF -> x0 reads 0 in that cycle and afterwards. BUSY_SET to x0 -> BUSY_OUT stays 0.
- BUSY_SET x7, then read x7 -> BUSY_OUT=1 next cycle. WE1 writes x7=0x00000042 three cycles later -> BUSY_OUT=0 during the write cycle (bypass) and afterwards, and data reads 0x00000042.
- BUSY_SET x9 and WE0 write x9 in the same cycle -> x9 stays busy. Then FLUSH with BUSY_SET x4 -> only x4 is busy.
- BYPASS=0 build: write x2=0xA5A5A5A5 while reading x2 -> old value 0 shown in that cycle, 0xA5A5A5A5 the next.
